ht_scfifo_sa: RTL and testbench

Single-clock synchronous FIFO with show-ahead (first-word-fall-through) read port.
- Used by the hash-table blocks as a free-list of empty bucket pointers.
- Also used as a general small buffer.
- The head word is always presented on rd_data_o while the FIFO is non-empty; rd_req_i acknowledges (pops) that word.

---
 rtl/ht_scfifo_sa.sv | 148 ++++++++++++++
 tb/tb_ht_scfifo_sa.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ht_scfifo_sa.sv
// ht_scfifo_sa -- single-clock synchronous FIFO with show-ahead read port.
//
// The head word is always presented on rd_data_o while the FIFO is non-empty.
// rd_req_i acknowledges (pops) that word. Used as the free-list of empty
// bucket pointers in the hash-table blocks and as a general small buffer.
//
// Parameters:
//   DATA_W     width of each stored word in bits
//   ADDR_W     address width; depth = 2**ADDR_W words
//
// Ports:
//   clk_i      clock; all state updates on the rising edge
//   rst_i      asynchronous active-low reset
//   srst_i     synchronous active-high clear; wins over wr_req_i and rd_req_i
//   wr_data_i  word to write
//   wr_req_i   write strobe; ignored while full_o=1
//   rd_req_i   read acknowledge; ignored while empty_o=1
//   rd_data_o  head-of-queue word; holds its last value while empty (0 after reset)
//   empty_o    FIFO holds zero words (registered)
//   full_o     FIFO holds 2**ADDR_W words (registered)
//   usedw_o    registered word count; present only with HT_SCFIFO_USEDW_EN
//
// Optional feature macro: HT_SCFIFO_USEDW_EN
module ht_scfifo_sa #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              srst_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_req_i,
    input  logic              rd_req_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              empty_o,
`ifdef HT_SCFIFO_USEDW_EN
    output logic              full_o,
    output logic [ADDR_W:0]   usedw_o
`else
    output logic              full_o
`endif
);

    localparam int unsigned      DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  CNT_ONE = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_inc;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              empty_q,  empty_d;
    logic              full_q,   full_d;
    logic [DATA_W-1:0] head_q,   head_d;
    logic              wr_acc;
    logic              rd_acc;

    // Acceptance depends only on registered flags, so a full FIFO rejects a
    // write even when a read is accepted in the same cycle.
    assign wr_acc     = wr_req_i & ~full_q;
    assign rd_acc     = rd_req_i & ~empty_q;
    assign rd_ptr_inc = rd_ptr_q + ADDR_W'(1);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        empty_d  = empty_q;
        full_d   = full_q;

        if (srst_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
            empty_d  = 1'b1;
            full_d   = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_inc;
            end

            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase

            empty_d = (count_d == '0);
            full_d  = (count_d == CNT_MAX);

            // Prefetch register: the next head is either the incoming word
            // (FIFO empty, or popping the last stored word while writing) or
            // the word behind the current head. The bypass covers the case
            // where the next head location is being written this same edge.
            if (count_d != '0) begin
                if (empty_q) begin
                    head_d = wr_data_i;
                end else if (rd_acc) begin
                    if (count_q == CNT_ONE) begin
                        head_d = wr_data_i;
                    end else begin
                        head_d = mem[rd_ptr_inc];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Storage is never cleared; a write coinciding with srst_i is discarded.
    always_ff @(posedge clk_i) begin
        if (wr_acc && !srst_i) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = head_q;
    assign empty_o   = empty_q;
    assign full_o    = full_q;
`ifdef HT_SCFIFO_USEDW_EN
    assign usedw_o   = count_q;
`endif

endmodule

// File: tb/tb_ht_scfifo_sa.sv
// tb_ht_scfifo_sa -- self-checking bench for ht_scfifo_sa (DATA_W=8, ADDR_W=2).
//
// A queue-based reference model tracks the stored words and the last word
// presented; directed steps follow the test plan, then a randomized phase.
module tb_ht_scfifo_sa;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;

    logic          clk_i;
    logic          rst_i;
    logic          srst_i;
    logic [DW-1:0] wr_data_i;
    logic          wr_req_i;
    logic          rd_req_i;
    logic [DW-1:0] rd_data_o;
    logic          empty_o;
    logic          full_o;
`ifdef HT_SCFIFO_USEDW_EN
    logic [AW:0]   usedw_o;
`endif

    ht_scfifo_sa #(
        .DATA_W(DW),
        .ADDR_W(AW)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .srst_i   (srst_i),
        .wr_data_i(wr_data_i),
        .wr_req_i (wr_req_i),
        .rd_req_i (rd_req_i),
        .rd_data_o(rd_data_o),
        .empty_o  (empty_o),
`ifdef HT_SCFIFO_USEDW_EN
        .full_o   (full_o),
        .usedw_o  (usedw_o)
`else
        .full_o   (full_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model_last;

    int unsigned n_tests;
    int unsigned n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".empty"}, 32'(empty_o), 32'(model_q.size() == 0));
        check({tag, ".full"},  32'(full_o),  32'(model_q.size() == DEPTH));
        check({tag, ".data"},  32'(rd_data_o), 32'(model_last));
`ifdef HT_SCFIFO_USEDW_EN
        check({tag, ".usedw"}, 32'(usedw_o), 32'(model_q.size()));
`endif
    endtask

    task automatic model_clear();
        model_q.delete();
        model_last = '0;
    endtask

    // One clock cycle: drive at negedge, update model at posedge, sample #1 later.
    task automatic step(input string tag, input logic wr, input logic [DW-1:0] wd,
                        input logic rd, input logic sr);
        bit wr_ok;
        bit rd_ok;
        @(negedge clk_i);
        wr_req_i  = wr;
        wr_data_i = wd;
        rd_req_i  = rd;
        srst_i    = sr;
        @(posedge clk_i);
        wr_ok = wr && (model_q.size() < DEPTH);
        rd_ok = rd && (model_q.size() > 0);
        if (sr) begin
            model_clear();
        end else begin
            if (rd_ok) void'(model_q.pop_front());
            if (wr_ok) model_q.push_back(wd);
            if (model_q.size() > 0) model_last = model_q[0];
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        wr_req_i  = 1'b0;
        rd_req_i  = 1'b0;
        srst_i    = 1'b0;
        wr_data_i = '0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_clear();
        idle_inputs();
        rst_i = 1'b0;

        // Power-on reset
        #12;
        check_all("por");
        @(negedge clk_i);
        rst_i = 1'b1;

        // Fill to full, then drain in order
        step("fill0", 1'b1, 8'h11, 1'b0, 1'b0);
        check("fill0.head", 32'(rd_data_o), 32'h11);
        step("fill1", 1'b1, 8'h22, 1'b0, 1'b0);
        step("fill2", 1'b1, 8'h33, 1'b0, 1'b0);
        step("fill3", 1'b1, 8'h44, 1'b0, 1'b0);
        check("fill3.full", 32'(full_o), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("drain.hold44", 32'(rd_data_o), 32'h44);
        check("drain.empty", 32'(empty_o), 32'h1);

        // Overflow cases
        step("refill0", 1'b1, 8'h11, 1'b0, 1'b0);
        step("refill1", 1'b1, 8'h22, 1'b0, 1'b0);
        step("refill2", 1'b1, 8'h33, 1'b0, 1'b0);
        step("refill3", 1'b1, 8'h44, 1'b0, 1'b0);
        step("ovf_norm", 1'b1, 8'h55, 1'b0, 1'b0);
        check("ovf_norm.head", 32'(rd_data_o), 32'h11);
        step("ovf_rd", 1'b1, 8'h66, 1'b1, 1'b0);
        check("ovf_rd.full", 32'(full_o), 32'h0);
        check("ovf_rd.head", 32'(rd_data_o), 32'h22);
        // count must be 3: one more write fills it
        step("ovf_top", 1'b1, 8'h99, 1'b0, 1'b0);
        check("ovf_top.full", 32'(full_o), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step("ovf_drain", 1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("ovf_drain.last", 32'(rd_data_o), 32'h99);

        // Underflow with simultaneous write
        step("udf", 1'b1, 8'h77, 1'b1, 1'b0);
        check("udf.head", 32'(rd_data_o), 32'h77);

        // Steady stream at count=2 across pointer wrap
        step("wrap_pre", 1'b1, 8'h80, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step("wrap", 1'b1, 8'(8'hA0 + i), 1'b1, 1'b0);
        end
        check("wrap.size", 32'(model_q.size()), 32'd2);

        // Synchronous clear with simultaneous write
        step("sr_pre", 1'b1, 8'hC1, 1'b0, 1'b0);
        step("srst", 1'b1, 8'hC2, 1'b0, 1'b1);
        check("srst.empty", 32'(empty_o), 32'h1);
        check("srst.data", 32'(rd_data_o), 32'h0);
        step("srst_post", 1'b1, 8'hD1, 1'b0, 1'b0);
        step("srst_post2", 1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle with 2 words stored
        step("ar_pre0", 1'b1, 8'hE1, 1'b0, 1'b0);
        step("ar_pre1", 1'b1, 8'hE2, 1'b0, 1'b0);
        @(negedge clk_i);
        idle_inputs();
        #2;
        rst_i = 1'b0;
        #1;
        model_clear();
        check_all("arst");
        @(negedge clk_i);
        rst_i = 1'b1;
        step("arst_post", 1'b1, 8'hF1, 1'b0, 1'b0);
        check("arst_post.head", 32'(rd_data_o), 32'hF1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
        end

        @(negedge clk_i);
        idle_inputs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
